// File: rtl/mult_pkg.sv
// Shared constants and types for the sequential Booth multiplier.
package mult_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into the accumulator,
// then an arithmetic right shift of the whole {acc, multiplier, q-1} register.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]     i_acc,  // accumulator, WIDTH+1 bits signed
  input  logic [WIDTH:0]     i_mq,   // {multiplier, q-1}; [1:0] is the Booth pair
  input  logic [WIDTH:0]     i_m,    // sign-extended multiplicand
  output logic [2*WIDTH+1:0] o_p     // next shifted P
);
  logic [WIDTH:0] w_sum;

  // Booth recoding of the pair: 01 adds M, 10 subtracts M, 00/11 pass through.
  always_comb begin
    w_sum = i_acc;
    case (i_mq[1:0])
      2'b01:   w_sum = i_acc + i_m;
      2'b10:   w_sum = i_acc - i_m;
      default: w_sum = i_acc;
    endcase
  end

  // Arithmetic shift right by one; the old q-1 bit falls off the bottom.
  assign o_p = {w_sum[WIDTH], w_sum, i_mq[WIDTH:1]};
endmodule

// File: rtl/multiplier_32.sv
// Sequential signed WIDTHxWIDTH multiplier, one Booth step per clock.
// The product register only changes on completion, so a reset or a new run
// never exposes a partial result.
module multiplier_32
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  output logic [2*WIDTH-1:0] ab,
  output logic               busy,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               clk,
  input  logic               start,
  input  logic               rst
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH:0]       r_m;
  logic [2*WIDTH+1:0]   r_p;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_ab;
  logic [2*WIDTH+1:0]   w_p_next;
  logic                 w_accept;
  logic                 w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_p[2*WIDTH+1:WIDTH+1]),
    .i_mq  (r_p[WIDTH:0]),
    .i_m   (r_m),
    .o_p   (w_p_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state: accept in IDLE, return to IDLE after the last Booth step.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, iterate while running, publish at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
      r_ab  <= '0;
    end else if (w_accept) begin
      r_m   <= {a[WIDTH-1], a};
      r_p   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
      r_cnt <= CW'(WIDTH);
    end else if (r_state == RUN) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt - CW'(1);
      // Product field is P[2W:1]; its top bit P[2W+1] is pure sign extension.
      if (w_last) r_ab <= w_p_next[2*WIDTH:1];
    end
  end

  assign ab   = r_ab;
  assign busy = (r_state == RUN);
endmodule

// File: tb/tb_multiplier_32.sv
// Directed bench for multiplier_32: reset, latency, held result, sign corners,
// abort on reset and back-to-back starts.
module tb_multiplier_32;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [63:0] ab;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multiplier_32 dut (
    .ab(ab), .busy(busy), .a(a), .b(b), .clk(clk), .start(start), .rst(rst)
  );

  // Launch one operation and count busy cycles; operands are scrambled while
  // busy to show they are not re-sampled.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input int hold,
                        input logic [63:0] old_ab, output int nbusy, output int nbad);
    nbusy = 0;
    nbad  = 0;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i + 1 >= hold) start = 1'b0;
      if (!busy) break;
      nbusy++;
      if (ab !== old_ab) nbad++;
      a = $urandom; b = $urandom;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (ab !== 64'd0) begin errors++; $display("FAIL reset_ab: got %h want 0", ab); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    int nb, nbad;
    run_op(32'd3, 32'd17, 5, 64'd0, nb, nbad);
    checks++;
    if (nb !== 32) begin errors++; $display("FAIL basic_latency: got %0d want 32", nb); end
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL basic_hold_old: got %0d bad cycles want 0", nbad); end
    checks++;
    if (ab !== 64'd51) begin errors++; $display("FAIL basic_ab: got %h want %h", ab, 64'd51); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ab !== 64'd51)
        begin errors++; $display("FAIL basic_after: got busy=%b ab=%h want busy=0 ab=%h", busy, ab, 64'd51); end
    end
  endtask

  task automatic test_neg();
    int nb, nbad;
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFF9, 1, 64'd51, nb, nbad);
    checks++;
    if (nb !== 32) begin errors++; $display("FAIL neg_latency: got %0d want 32", nb); end
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL neg_hold_old: got %0d bad cycles want 0", nbad); end
    checks++;
    if (ab !== 64'd49) begin errors++; $display("FAIL neg_ab: got %h want %h", ab, 64'd49); end
  endtask

  task automatic test_corners();
    logic [31:0] va [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] vb [4] = '{32'hFFFF_FFFB, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
    logic [63:0] ve [4] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000,
                            64'hC000_0000_8000_0000};
    logic [63:0] prev = 64'd49;
    int nb, nbad;
    for (int k = 0; k < 4; k++) begin
      run_op(va[k], vb[k], 1, prev, nb, nbad);
      checks++;
      if (nb !== 32 || nbad !== 0)
        begin errors++; $display("FAIL corner%0d_timing: got busy=%0d bad=%0d want 32/0", k, nb, nbad); end
      checks++;
      if (ab !== ve[k]) begin errors++; $display("FAIL corner%0d_ab: got %h want %h", k, ab, ve[k]); end
      prev = ve[k];
    end
  endtask

  task automatic test_reset_mid();
    int nb, nbad;
    @(negedge clk);
    a = 32'd6; b = 32'd7; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_running: got busy=%b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++;
    if (ab !== 64'd0) begin errors++; $display("FAIL mid_ab: got %h want 0", ab); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ab !== 64'd0)
      begin errors++; $display("FAIL mid_after: got busy=%b ab=%h want 0/0", busy, ab); end
    run_op(32'd2, 32'd3, 1, 64'd0, nb, nbad);
    checks++;
    if (nb !== 32 || nbad !== 0)
      begin errors++; $display("FAIL mid_rerun_timing: got busy=%0d bad=%0d want 32/0", nb, nbad); end
    checks++;
    if (ab !== 64'd6) begin errors++; $display("FAIL mid_rerun_ab: got %h want %h", ab, 64'd6); end
  endtask

  task automatic test_back_to_back();
    int n1 = 0, n2 = 0, nbad = 0;
    @(negedge clk);
    a = 32'd5; b = 32'hFFFF_FFFC; start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n1++;
    end
    checks++;
    if (n1 !== 32) begin errors++; $display("FAIL b2b_first_latency: got %0d want 32", n1); end
    checks++;
    if (ab !== 64'hFFFF_FFFF_FFFF_FFEC)
      begin errors++; $display("FAIL b2b_first_ab: got %h want %h", ab, 64'hFFFF_FFFF_FFFF_FFEC); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_rearm: got busy=%b want 1", busy); end
    start = 1'b0;
    if (busy) begin
      n2 = 1;
      for (int i = 0; i < 100; i++) begin
        if (ab !== 64'hFFFF_FFFF_FFFF_FFEC) nbad++;
        @(negedge clk);
        if (!busy) break;
        n2++;
      end
    end
    checks++;
    if (n2 !== 32 || nbad !== 0)
      begin errors++; $display("FAIL b2b_second_timing: got busy=%0d bad=%0d want 32/0", n2, nbad); end
    checks++;
    if (ab !== 64'hFFFF_FFFF_FFFF_FFEC)
      begin errors++; $display("FAIL b2b_second_ab: got %h want %h", ab, 64'hFFFF_FFFF_FFFF_FFEC); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg();
    test_corners();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end
endmodule
